// File: rtl/wash_pkg.sv
// wash_pkg: shared states, programme modes, default durations and wash-length lookup
package wash_pkg;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    DRAIN = 3'd3,
    SPIN  = 3'd4,
    PAUSE = 3'd5
  } state_t;
  typedef enum logic [1:0] {
    M_SPIN   = 2'd0,
    M_SMALL  = 2'd1,
    M_MEDIUM = 2'd2,
    M_LARGE  = 2'd3
  } mode_t;
  localparam int TICK_CYCLES_D = 100000000;
  localparam int FILL_S_D      = 3;
  localparam int WASH_S_SM_D   = 4;
  localparam int WASH_S_MD_D   = 6;
  localparam int WASH_S_LG_D   = 8;
  localparam int DRAIN_S_D     = 2;
  localparam int SPIN_S_D      = 3;
  function automatic logic [7:0] wash_secs(input mode_t m, input logic [7:0] sm, md, lg);
    return m == M_SMALL ? sm : m == M_MEDIUM ? md : m == M_LARGE ? lg : 8'd0;
  endfunction
endpackage

// File: rtl/wash_sequencer_sec_tick.sv
// sec_tick: free-running per-second tick counter with enable, clear and wrap flag
module sec_tick #(
  parameter int TICK_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic last,
  output logic tick
);
  localparam int W = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  logic [W-1:0] cnt;
  assign last = cnt == W'(TICK_CYCLES - 1);
  assign tick = en && last;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en) cnt <= last ? '0 : cnt + 1'b1;
endmodule

// File: rtl/wash_sequencer.sv
// wash_sequencer: fill/wash/drain/spin programme sequencer with pause, abort and remaining-time output
module wash_sequencer
  import wash_pkg::*;
#(
  parameter int TICK_CYCLES = TICK_CYCLES_D,
  parameter int FILL_S      = FILL_S_D,
  parameter int WASH_S_SM   = WASH_S_SM_D,
  parameter int WASH_S_MD   = WASH_S_MD_D,
  parameter int WASH_S_LG   = WASH_S_LG_D,
  parameter int DRAIN_S     = DRAIN_S_D,
  parameter int SPIN_S      = SPIN_S_D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode,
  input  logic       pause_bt,
  input  logic       abort,
  output logic [2:0] phase,
  output logic [7:0] remain_s,
  output logic       busy,
  output logic       door_lock,
  output logic       valve_in,
  output logic       valve_out,
  output logic       motor_on,
  output logic       motor_fast,
  output logic       aborted,
  output logic       done
);
  state_t state, nxt, resume, view, after;
  mode_t mode_q;
  logic [7:0] phase_sec, ld_sec, wash_len, later;
  logic run, pause_req, abort_req, entry, last, tick;
  assign run = state inside {FILL, WASH, DRAIN, SPIN};
  assign abort_req = abort && state inside {FILL, WASH, SPIN, PAUSE};
  assign pause_req = run && pause_bt && !abort;
  assign wash_len = wash_secs(mode_q, 8'(WASH_S_SM), 8'(WASH_S_MD), 8'(WASH_S_LG));
  sec_tick #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (run && !pause_req),
    .clr (entry || (pause_req && last)),
    .last(last),
    .tick(tick)
  );
  always_comb begin
    after = state == FILL ? WASH : state == WASH ? DRAIN :
            state == DRAIN ? ((aborted || abort) ? IDLE : SPIN) : IDLE;
    nxt = state;
    case (state)
      IDLE:    nxt = start ? (mode_t'(mode) == M_SPIN ? SPIN : FILL) : IDLE;
      PAUSE:   nxt = abort_req ? DRAIN : pause_bt ? resume : PAUSE;
      default: nxt = abort_req ? DRAIN : pause_req ? PAUSE : (tick && phase_sec == 8'd1) ? after : state;
    endcase
    entry = nxt != state && nxt != IDLE && nxt != PAUSE && !(state == PAUSE && !abort_req);
    ld_sec = nxt == FILL ? 8'(FILL_S) : nxt == WASH ? wash_len : nxt == DRAIN ? 8'(DRAIN_S) : 8'(SPIN_S);
    view = state == PAUSE ? resume : state;
    later = view == FILL ? wash_len + 8'(DRAIN_S + SPIN_S) :
            view == WASH ? 8'(DRAIN_S + SPIN_S) :
            (view == DRAIN && !aborted) ? 8'(SPIN_S) : 8'd0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      resume    <= IDLE;
      mode_q    <= M_SPIN;
      phase_sec <= '0;
      aborted   <= 1'b0;
      done      <= 1'b0;
    end else begin
      state <= nxt;
      done  <= run && nxt == IDLE;
      if (pause_req) resume <= state;
      if (entry) phase_sec <= ld_sec;
      else if (tick) phase_sec <= phase_sec - 8'd1;
      if (state == IDLE && start) begin
        mode_q  <= mode_t'(mode);
        aborted <= 1'b0;
      end else if (abort && state != IDLE) aborted <= 1'b1;
    end
  assign phase      = state;
  assign remain_s   = state == IDLE ? 8'd0 : phase_sec + later;
  assign busy       = state != IDLE;
  assign door_lock  = state != IDLE;
  assign valve_in   = state == FILL;
  assign valve_out  = state == DRAIN || state == SPIN;
  assign motor_on   = state == WASH || state == SPIN;
  assign motor_fast = state == SPIN;
endmodule

// File: doc/wash_sequencer.md
Name: wash_sequencer

Overview:
Sequences one wash programme after the billing stage confirms payment. It steps through the FILL, WASH, DRAIN and SPIN phases with per-mode durations and drives the water valves, the motor and the door lock. It supports pause/resume and abort, reports the total remaining seconds for the 7-segment display, and pulses `done` back to billing so it can enter its wait-for-collection / idle-penalty flow.

Parameters:
- TICK_CYCLES, 100000000: clk cycles per 1-second tick. Benches use 4.
- FILL_S, 3: fill duration in seconds.
- WASH_S_SM, 4: wash seconds for the small load.
- WASH_S_MD, 6: wash seconds for the medium load.
- WASH_S_LG, 8: wash seconds for the large load.
- DRAIN_S, 2: drain seconds.
- SPIN_S, 3: spin seconds.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; payment confirmed.
- mode  in  2  programme select: 00 spin-only, 01 small, 10 medium, 11 large.
- pause_bt  in  1  debounced one-cycle pulse; toggles pause.
- abort  in  1  one-cycle pulse; cancel the programme.
- phase  out  3  current state encoding.
- remain_s  out  8  binary seconds left in the whole programme.
- busy  out  1  high in any state other than IDLE.
- door_lock  out  1  high in any state other than IDLE.
- valve_in  out  1  inlet valve.
- valve_out  out  1  drain valve.
- motor_on  out  1  drum motor.
- motor_fast  out  1  spin speed select.
- aborted  out  1  set when an abort is accepted; cleared on the next accepted start.
- done  out  1  one-cycle pulse when the programme finishes.

Behaviour:
- Reset (asynchronous, rst=1):
  - State: IDLE.
  - All outputs 0; remain_s=0.
  - Tick counter, phase seconds and mode latch cleared.
- States: IDLE, FILL, WASH, DRAIN, SPIN, PAUSE. PAUSE stores the interrupted phase in a resume register.
- Start:
  - A start pulse while in IDLE latches mode and clears aborted.
  - The next cycle enters FILL, or SPIN when mode=00.
  - Start outside IDLE is ignored.
- Phase entry: load phase_sec with that phase's duration and clear the tick counter.
- Timing:
  - The tick counter counts 0..TICK_CYCLES-1 while in a running phase. On wrap, phase_sec decrements.
  - When phase_sec==1 and a tick fires, move to the next phase in the same cycle.
  - Each phase therefore lasts exactly duration×TICK_CYCLES cycles.
- Phase order:
  - Modes 01/10/11: FILL→WASH→DRAIN→SPIN→IDLE.
  - Mode 00: SPIN→IDLE.
- done: asserted for one cycle, registered, in the first cycle back in IDLE.
- Outputs per state:
  - FILL: valve_in=1.
  - WASH: motor_on=1.
  - DRAIN: valve_out=1.
  - SPIN: motor_on=1, motor_fast=1, valve_out=1.
  - PAUSE and IDLE: all actuators 0.
  - door_lock stays 1 in PAUSE.
- remain_s:
  - Equals phase_sec plus the durations of all later phases on the latched path, computed combinationally.
  - In PAUSE it holds its value.
  - In IDLE it is 0.
- Pause:
  - pause_bt in a running phase enters PAUSE next cycle; the tick counter and phase_sec freeze.
  - pause_bt in PAUSE returns to the stored phase with the counters intact.
  - pause_bt in IDLE is ignored.
- Abort:
  - Abort in FILL, WASH, SPIN or PAUSE sets aborted, enters DRAIN with DRAIN_S and a cleared tick counter, and then goes to IDLE. SPIN is skipped.
  - Abort during DRAIN sets aborted and the drain continues unchanged.
  - Abort in IDLE is ignored.
  - done still pulses at the end of an aborted programme.
- Simultaneous events:
  - abort beats pause_bt.
  - abort or pause_bt beats a tick-driven phase advance in the same cycle.
  - A pause on the final tick of a phase enters PAUSE, and the resume target is the phase that was running. phase_sec stays 1 and the tick counter is cleared to 0.
- Mode changes after start have no effect until the next start.
- Reset mid-programme returns to IDLE immediately with all actuators off and no done pulse.

Decomposition:
- Package wash_pkg:
  - State encodings: IDLE=0, FILL=1, WASH=2, DRAIN=3, SPIN=4, PAUSE=5.
  - Mode encodings.
  - Default second constants.
  - Function wash_secs(mode).
- Sub-module sec_tick: tick counter with enable and clear inputs and a one-cycle tick output, parameterised by TICK_CYCLES.

Test Plan:
1. Mode 01, TICK_CYCLES=4, start pulse at cycle 0:
   - FILL at cycle 1 with remain_s=12.
   - WASH at cycle 13, DRAIN at 29, SPIN at 37.
   - done=1 at cycle 49 only; busy and door_lock fall at 49.
2. Mode 00, start → SPIN only with remain_s=3; done at 12 cycles after SPIN entry; valve_in never 1.
3. Mode 11, pause_bt 5 cycles into WASH:
   - PAUSE, actuators 0, remain_s frozen.
   - After 20 cycles, pause_bt resumes WASH.
   - done is delayed by exactly 20 + 2 cycles versus an unpaused run.
4. Mode 10, abort during WASH → DRAIN next cycle with aborted=1; IDLE after 8 cycles; done pulses; SPIN never entered.
5. Same-cycle abort+pause_bt in FILL → DRAIN, not PAUSE. Start pulse during DRAIN → ignored; mode latch unchanged.
6. rst pulse mid-SPIN → all outputs 0 asynchronously, no done. A following start runs a full programme normally.
